// File: rtl/risc16_pkg.sv
// Shared constants and loader FSM encodings for the risc16 core and its program loader.
package risc16_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [2:0] {
    CNT_HI,
    CNT_LO,
    DAT_HI,
    DAT_LO,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: count, words, XOR checksum; one mem write per word, issued the cycle after its low byte.
// Accepts a byte every cycle in the loading states; rx_ready is registered and drops only in DONE/ERR.
module imem_loader
  import risc16_pkg::*;
#(
  parameter int P_INST_NUM = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              start,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              err
);

  localparam logic [WORD_W:0]   INST_LIM = (WORD_W + 1)'(P_INST_NUM);
  localparam logic [WORD_W-1:0] ONE      = WORD_W'(1);

  loader_state_t     state;
  logic [7:0]        hi_byte;
  logic [7:0]        xor_acc;
  logic [WORD_W-1:0] word_cnt;
  logic [WORD_W-1:0] word_idx;
  logic              accept;
  logic [WORD_W-1:0] byte_pair;

  assign accept    = rx_valid & rx_ready;
  // hi_byte holds the count MSB in CNT_LO and the word MSB in DAT_LO.
  assign byte_pair = {hi_byte, rx_data};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= CNT_HI;
      rx_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      core_rst  <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      hi_byte   <= '0;
      xor_acc   <= '0;
      word_cnt  <= '0;
      word_idx  <= '0;
    end else begin
      mem_we <= 1'b0;
      if (accept) begin
        xor_acc <= xor_acc ^ rx_data;
      end
      case (state)
        CNT_HI: begin
          rx_ready <= 1'b1;
          if (accept) begin
            hi_byte <= rx_data;
            state   <= CNT_LO;
          end
        end
        CNT_LO: begin
          if (accept) begin
            word_cnt <= byte_pair;
            if (byte_pair == '0) begin
              state <= CSUM;
            end else if ({1'b0, byte_pair} > INST_LIM) begin
              state    <= ERR;
              rx_ready <= 1'b0;
              err      <= 1'b1;
            end else begin
              state <= DAT_HI;
            end
          end
        end
        DAT_HI: begin
          if (accept) begin
            hi_byte <= rx_data;
            state   <= DAT_LO;
          end
        end
        DAT_LO: begin
          if (accept) begin
            mem_we    <= 1'b1;
            mem_addr  <= word_idx;
            mem_wdata <= byte_pair;
            // Index stops at N-1 so it never points past the loaded image.
            if (word_idx == word_cnt - ONE) begin
              state <= CSUM;
            end else begin
              word_idx <= word_idx + ONE;
              state    <= DAT_HI;
            end
          end
        end
        CSUM: begin
          if (accept) begin
            rx_ready <= 1'b0;
            if (rx_data == xor_acc) begin
              state    <= DONE;
              done     <= 1'b1;
              core_rst <= 1'b0;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
        DONE, ERR: begin
          if (start) begin
            state    <= CNT_HI;
            rx_ready <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            core_rst <= 1'b1;
            xor_acc  <= '0;
            word_idx <= '0;
          end
        end
        default: begin
          state    <= ERR;
          rx_ready <= 1'b0;
          core_rst <= 1'b1;
          done     <= 1'b0;
          err      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: reset values, table-driven loads, reset-abort sequence, randomized loads against a stream-parsing model.
module tb_imem_loader;

  localparam int INST_NUM = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        start;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        core_rst;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  imem_loader #(.P_INST_NUM(INST_NUM)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .start    (start),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .core_rst (core_rst),
    .done     (done),
    .err      (err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] got[$];
  logic [31:0] exp_w[$];
  bit          exp_done;
  bit          exp_err;
  int          exp_len;

  // Every cycle with mem_we high is one observed write {addr, data}.
  always @(negedge clk) begin
    if (mem_we) got.push_back({mem_addr, mem_wdata});
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: parse the stream by its format rules and derive writes, outcome, and accepted length.
  task automatic model(input logic [7:0] s[$]);
    int         n;
    logic [7:0] x;
    exp_w.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_len  = s.size();
    if (s.size() < 2) return;
    n = int'({s[0], s[1]});
    if (n > INST_NUM) begin
      exp_err = 1'b1;
      exp_len = 2;
      return;
    end
    if (s.size() < 2 * n + 3) return;
    for (int i = 0; i < n; i++) exp_w.push_back({16'(i), s[2 + 2 * i], s[3 + 2 * i]});
    x = 8'h00;
    for (int i = 0; i < 2 * n + 2; i++) x ^= s[i];
    exp_len = 2 * n + 3;
    if (s[2 * n + 2] == x) exp_done = 1'b1;
    else exp_err = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_pct, output bit ok);
    int g = 0;
    ok = 1'b0;
    while (gap_pct > 0 && g < 4 && $urandom_range(99) < gap_pct) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      start    = ($urandom_range(7) == 0);
      g++;
    end
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      start    = (gap_pct > 0) && ($urandom_range(7) == 0);
      if (rx_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drive_stream(input logic [7:0] s[$], input int len, input int gap_pct, input string tag);
    bit ok;
    int sent = 0;
    for (int i = 0; i < len; i++) begin
      send_byte(s[i], gap_pct, ok);
      if (!ok) break;
      sent++;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    start    = 1'b0;
    check({tag, " bytes accepted"}, 32'(sent), 32'(len));
  endtask

  task automatic check_outcome(input string tag, input bit de, input bit ee, input logic [31:0] w[$]);
    repeat (2) @(negedge clk);
    check({tag, " done"}, 32'(done), 32'(de));
    check({tag, " err"}, 32'(err), 32'(ee));
    check({tag, " core_rst"}, 32'(core_rst), 32'(!de));
    check({tag, " rx_ready"}, 32'(rx_ready), 32'(0));
    check({tag, " write count"}, 32'(got.size()), 32'(w.size()));
    for (int i = 0; i < w.size() && i < got.size(); i++) check({tag, " write"}, got[i], w[i]);
  endtask

  task automatic restart(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " restart rx_ready"}, 32'(rx_ready), 32'(1));
    check({tag, " restart done"}, 32'(done), 32'(0));
    check({tag, " restart err"}, 32'(err), 32'(0));
    check({tag, " restart core_rst"}, 32'(core_rst), 32'(1));
  endtask

  task automatic build(input int n, input bit bad, output logic [7:0] s[$]);
    logic [7:0] x = 8'h00;
    s.delete();
    s.push_back(8'(n >> 8));
    s.push_back(8'(n));
    if (n <= INST_NUM) begin
      for (int i = 0; i < 2 * n; i++) s.push_back(8'($urandom));
      foreach (s[i]) x ^= s[i];
      s.push_back(bad ? (x ^ 8'(1 << $urandom_range(7))) : x);
    end
  endtask

  task automatic run_rand(input logic [7:0] s[$], input int gap_pct, input string tag);
    model(s);
    got.delete();
    drive_stream(s, exp_len, gap_pct, tag);
    check_outcome(tag, exp_done, exp_err, exp_w);
    restart(tag);
  endtask

  typedef struct {
    string       name;
    logic [15:0] n;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [7:0]  flip;
    bit          done_e;
    bit          err_e;
    int          nw;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [7:0]  s[$];
    logic [31:0] w[$];
    logic [7:0]  x;

    vecs[0] = '{"basic",    16'd2,      16'h1234, 16'hABCD, 8'h00, 1'b1, 1'b0, 2};
    vecs[1] = '{"bad_csum", 16'd2,      16'h1234, 16'hABCD, 8'h01, 1'b0, 1'b1, 2};
    vecs[2] = '{"over_cnt", 16'h0401,   16'h0000, 16'h0000, 8'h00, 1'b0, 1'b1, 0};
    vecs[3] = '{"empty",    16'd0,      16'h0000, 16'h0000, 8'h00, 1'b1, 1'b0, 0};
    vecs[4] = '{"one_word", 16'd1,      16'hFFFF, 16'h0000, 8'h00, 1'b1, 1'b0, 1};
    vecs[5] = '{"empty_bad",16'd0,      16'h0000, 16'h0000, 8'h80, 1'b0, 1'b1, 0};
    vecs[6] = '{"max_cnt",  16'hFFFF,   16'h0000, 16'h0000, 8'h00, 1'b0, 1'b1, 0};

    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    start    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset rx_ready", 32'(rx_ready), 32'(0));
    check("reset mem_we", 32'(mem_we), 32'(0));
    check("reset mem_addr", 32'(mem_addr), 32'(0));
    check("reset mem_wdata", 32'(mem_wdata), 32'(0));
    check("reset core_rst", 32'(core_rst), 32'(1));
    check("reset done", 32'(done), 32'(0));
    check("reset err", 32'(err), 32'(0));
    rst = 1'b1;
    #1;
    check("rx_ready before first edge", 32'(rx_ready), 32'(0));
    @(negedge clk);
    check("rx_ready after first edge", 32'(rx_ready), 32'(1));

    for (int v = 0; v < 7; v++) begin
      s.delete();
      w.delete();
      s.push_back(vecs[v].n[15:8]);
      s.push_back(vecs[v].n[7:0]);
      if (vecs[v].n <= 16'd2) begin
        if (vecs[v].n >= 16'd1) begin
          s.push_back(vecs[v].w0[15:8]);
          s.push_back(vecs[v].w0[7:0]);
        end
        if (vecs[v].n == 16'd2) begin
          s.push_back(vecs[v].w1[15:8]);
          s.push_back(vecs[v].w1[7:0]);
        end
        x = 8'h00;
        foreach (s[i]) x ^= s[i];
        s.push_back(x ^ vecs[v].flip);
      end
      if (vecs[v].nw >= 1) w.push_back({16'h0000, vecs[v].w0});
      if (vecs[v].nw >= 2) w.push_back({16'h0001, vecs[v].w1});
      got.delete();
      drive_stream(s, s.size(), 0, vecs[v].name);
      check_outcome(vecs[v].name, vecs[v].done_e, vecs[v].err_e, w);
      restart(vecs[v].name);
    end

    // Reset in the middle of a load: the partial write stays, then a clean reload succeeds.
    s = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    got.delete();
    drive_stream(s, 5, 0, "abort");
    check("abort partial writes", 32'(got.size()), 32'(1));
    if (got.size() > 0) check("abort partial write", got[0], 32'h0000_1122);
    rst   = 1'b0;
    start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort mem_we in reset", 32'(mem_we), 32'(0));
    end
    check("abort rx_ready in reset", 32'(rx_ready), 32'(0));
    check("abort core_rst in reset", 32'(core_rst), 32'(1));
    check("abort done in reset", 32'(done), 32'(0));
    check("abort err in reset", 32'(err), 32'(0));
    check("abort writes in reset", 32'(got.size()), 32'(1));
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    got.delete();
    s = '{8'h00, 8'h01, 8'h55, 8'h55, 8'h01};
    drive_stream(s, 5, 0, "reload");
    w = '{32'h0000_5555};
    check_outcome("reload", 1'b1, 1'b0, w);
    restart("reload");

    // Same N=3 stream with and without valid gaps must give identical writes.
    build(3, 1'b0, s);
    run_rand(s, 0, "n3 nogap");
    run_rand(s, 60, "n3 gap");

    for (int k = 0; k < 12; k++) begin
      int n;
      n = ($urandom_range(5) == 0) ? 0 : int'($urandom_range(1, 8));
      build(n, $urandom_range(3) == 0, s);
      run_rand(s, int'($urandom_range(0, 60)), "rand");
    end

    build(INST_NUM, 1'b0, s);
    run_rand(s, 0, "full depth");
    build(int'($urandom_range(INST_NUM + 1, 65535)), 1'b0, s);
    run_rand(s, 20, "rand over");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
